eco32_core_ifu_evm_arb: RTL and testbench
=========================================

Name: eco32_core_ifu_evm_arb

Overview:
- Event collection and arbitration stage directly upstream of the IFU event manager.
- Latches up to EVT_NUM single-cycle event strobes, each with a 4-bit erx payload, into per-source pending slots.
- Arbitrates pending, unmasked slots round-robin and presents one event at a time on a stb/eid/erx interface held stable until acknowledged.
- Flags events that arrive while their slot is still pending as sticky overflow.

Parameters:
- EVT_NUM, 16, number of event sources; legal range 2..16; eid = source index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ev_stb  in  EVT_NUM  per-source event strobe, one-cycle pulse per event.
- ev_erx  in  4*EVT_NUM  per-source payload; bits [4k+3:4k] belong to source k; valid with ev_stb[k].
- ev_mask  in  EVT_NUM  1 = source eligible for arbitration. Masked sources still latch events.
- o_stb  out  1  event presented to the manager.
- o_eid  out  4  source index of the presented event.
- o_erx  out  4  payload of the presented event.
- o_ack  in  1  one-cycle acknowledge from the manager; consumes the presented event.
- ovf_flags  out  EVT_NUM  sticky per-source overflow.
- ovf_clr  in  1  clears all ovf_flags.
- pend_cnt  out  5  number of pending slots, masked and unmasked.

Behaviour:
- Reset: all pending bits, erx slots and ovf_flags are 0; rr_ptr = EVT_NUM-1; state IDLE. Outputs o_stb=0, o_eid=0, o_erx=0, ovf_flags=0, pend_cnt=0.
- Capture: ev_stb[k]=1 at edge t sets pend[k] and writes erx_slot[k] from ev_erx[k] at t.
- Re-strobe of a pending source:
  - Not being cleared in the same cycle: ovf_flags[k] sets and erx_slot[k] is overwritten with the newest value.
  - Being cleared in the same cycle (o_ack for the locked source k): pend[k] stays 1 with the new erx. No overflow.
- Selection: candidates = pend & ev_mask. The first candidate searching from rr_ptr+1 upward, wrapping at EVT_NUM-1 to 0, is selected. rr_ptr itself is searched last.
- State IDLE:
  - o_stb=0.
  - If any candidate exists: register sel_eid and sel_erx = erx_slot[sel], go to LOCK.
- State LOCK:
  - o_stb=1; o_eid=sel_eid and o_erx=sel_erx, held stable throughout.
  - On o_ack: clear pend[sel] (subject to the re-strobe rule), rr_ptr <= sel, go to IDLE.
- Latency: strobe at edge t, pend visible after t, o_stb high after edge t+1 (minimum two cycles). After an ack, the next event is presented two cycles later (IDLE, then LOCK).
- Locked source behaviour:
  - Clearing ev_mask for the locked source in LOCK does not withdraw o_stb.
  - A re-strobe of the locked source before ack sets ovf_flags; the ack then clears pend, and the overwritten newer erx is lost.
- o_ack in IDLE is ignored, with no state change.
- ovf_clr:
  - Clears all ovf_flags.
  - A simultaneous overflow event wins for its bit (flag stays 1).
- pend_cnt: registered population count of pend, updated one cycle after pend changes.
- Reset asserted mid-LOCK: o_stb drops immediately (asynchronous) and all pending events are discarded.
- Sources with index >= EVT_NUM do not exist; o_eid is never >= EVT_NUM.

Test Plan:
- Single event: ev_stb[5]=1, ev_erx[23:20]=4'hA, ev_mask=all ones.
  - Required: o_stb rises 2 cycles later with o_eid=5, o_erx=A.
  - Outputs held for 10 cycles of no ack.
  - o_ack pulse gives o_stb=0 next cycle and pend_cnt returns to 0.
- Round-robin: strobe sources 1, 3 and 14 together, ack each presentation immediately.
  - Required: order 1, 3, 14.
  - Then re-strobe 1 and 3: order is 1 then 3, because rr_ptr=14 wraps to 1.
- Mask: pend sources 2 and 7, ev_mask[2]=0.
  - Required: only 7 is presented.
  - Set ev_mask[2]=1: 2 is presented next.
  - pend_cnt=2 before any ack.
- Overflow: strobe source 4 twice, erx 1 then 2, with 4 locked after the first.
  - Required: ovf_flags[4]=1, presented erx stays 1.
  - After ack, pend[4]=0.
  - ovf_clr clears the flag.
- Same-cycle ack and strobe: source 9 locked, ev_stb[9] with erx=6 on the o_ack cycle.
  - Required: no overflow.
  - Source 9 re-presented with o_erx=6.
- Reset mid-operation: assert rst while in LOCK with 3 pending.
  - Required: o_stb=0 asynchronously and pend_cnt=0.
  - After release, no event is presented until a new strobe.

Source files
------------

// File: rtl/eco32_core_ifu_evm_arb.sv
// -----------------------------------------------------------------------------
// eco32_core_ifu_evm_arb
//
// Event collection and round-robin arbitration in front of the IFU event
// manager. Each source k owns one pending slot (pend bit + 4-bit erx). A
// strobe on an idle slot captures the event. A strobe on a slot that is still
// pending overwrites the payload and raises a sticky overflow flag, unless the
// same edge consumes that slot through an ack. Pending, unmasked slots are
// offered one at a time on o_stb/o_eid/o_erx, and each offer is held until
// o_ack.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   ev_stb     per-source one-cycle event strobe
//   ev_erx     per-source payload, bits [4k+3:4k] belong to source k
//   ev_mask    1 = source may win arbitration (masked sources still capture)
//   o_stb      event presented to the manager
//   o_eid      source index of the presented event
//   o_erx      payload of the presented event
//   o_ack      one-cycle acknowledge, consumes the presented event
//   ovf_flags  sticky per-source overflow
//   ovf_clr    clears all overflow flags (a same-cycle overflow wins)
//   pend_cnt   registered population count of the pending slots
// -----------------------------------------------------------------------------
module eco32_core_ifu_evm_arb #(
    parameter int EVT_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EVT_NUM-1:0]   ev_stb,
    input  logic [4*EVT_NUM-1:0] ev_erx,
    input  logic [EVT_NUM-1:0]   ev_mask,
    output logic                 o_stb,
    output logic [3:0]           o_eid,
    output logic [3:0]           o_erx,
    input  logic                 o_ack,
    output logic [EVT_NUM-1:0]   ovf_flags,
    input  logic                 ovf_clr,
    output logic [4:0]           pend_cnt
);

    // Internal vectors are padded to the 16 sources a 4-bit eid can name, so
    // eid-indexed selects keep a fixed index width for any legal EVT_NUM.
    localparam int          MAX_SRC   = 16;
    localparam logic [15:0] SRC_VALID = 16'((32'd1 << EVT_NUM) - 32'd1);
    localparam logic [3:0]  RR_RESET  = 4'(EVT_NUM - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Population count of a 16-bit vector.
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < MAX_SRC; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Registered state
    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] ovf_q, ovf_d;
    logic [3:0]  erx_slot_q [MAX_SRC];
    logic [3:0]  erx_slot_d [MAX_SRC];
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  sel_eid_q, sel_eid_d;
    logic [3:0]  sel_erx_q, sel_erx_d;
    logic        o_stb_q, o_stb_d;
    logic [4:0]  pend_cnt_q, pend_cnt_d;

    // Combinational helpers
    logic [15:0] stb_pad_s;
    logic [15:0] mask_pad_s;
    logic [3:0]  erx_in_s [MAX_SRC];
    logic [15:0] cand_s;
    logic        found_s;
    logic [3:0]  pick_s;
    logic        lock_ack_s;
    logic [15:0] clr_s;
    logic [15:0] ovf_set_s;

    // Widen the per-source inputs to the padded 16-source view.
    always_comb begin
        stb_pad_s  = 16'd0;
        mask_pad_s = 16'd0;
        stb_pad_s[EVT_NUM-1:0]  = ev_stb;
        mask_pad_s[EVT_NUM-1:0] = ev_mask;
        for (int k = 0; k < MAX_SRC; k++) begin
            if (k < EVT_NUM) begin
                erx_in_s[k] = ev_erx[4*k +: 4];
            end else begin
                erx_in_s[k] = 4'd0;
            end
        end
    end

    // Round-robin pick: search rr_ptr+1 upward with wrap, rr_ptr itself last.
    always_comb begin
        logic [4:0] idx_v;
        cand_s  = pend_q & mask_pad_s & SRC_VALID;
        found_s = 1'b0;
        pick_s  = 4'd0;
        idx_v   = 5'd0;
        for (int i = 1; i <= EVT_NUM; i++) begin
            idx_v = {1'b0, rr_ptr_q} + 5'(i);
            if (idx_v >= 5'(EVT_NUM)) begin
                idx_v = idx_v - 5'(EVT_NUM);
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && cand_s[idx_v[3:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_v[3:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Presentation FSM: IDLE latches the winner, LOCK holds it until ack.
    always_comb begin
        state_d    = state_q;
        sel_eid_d  = sel_eid_q;
        sel_erx_d  = sel_erx_q;
        rr_ptr_d   = rr_ptr_q;
        lock_ack_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An ack seen here has nothing to consume and is dropped.
                if (found_s) begin
                    state_d   = ST_LOCK;
                    sel_eid_d = pick_s;
                    sel_erx_d = erx_slot_q[pick_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                // Mask changes are ignored here: the offer is never withdrawn.
                if (o_ack) begin
                    lock_ack_s = 1'b1;
                    rr_ptr_d   = sel_eid_q;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending slots, payload capture, overflow and the registered outputs.
    always_comb begin
        clr_s = lock_ack_s ? (16'd1 << sel_eid_q) : 16'd0;
        // A strobe into a slot that survives this edge loses the older event.
        ovf_set_s = stb_pad_s & pend_q & ~clr_s;
        // A strobe on the slot being acked re-arms it instead of overflowing.
        pend_d = (stb_pad_s | (pend_q & ~clr_s)) & SRC_VALID;
        if (ovf_clr) begin
            ovf_d = ovf_set_s;
        end else begin
            ovf_d = ovf_q | ovf_set_s;
        end
        for (int k = 0; k < MAX_SRC; k++) begin
            if (stb_pad_s[k]) begin
                erx_slot_d[k] = erx_in_s[k];
            end else begin
                erx_slot_d[k] = erx_slot_q[k];
            end
        end
        o_stb_d    = (state_d == ST_LOCK);
        pend_cnt_d = popcnt16(pend_q);
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= 16'd0;
            ovf_q      <= 16'd0;
            rr_ptr_q   <= RR_RESET;
            sel_eid_q  <= 4'd0;
            sel_erx_q  <= 4'd0;
            o_stb_q    <= 1'b0;
            pend_cnt_q <= 5'd0;
            for (int k = 0; k < MAX_SRC; k++) begin
                erx_slot_q[k] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_eid_q  <= sel_eid_d;
            sel_erx_q  <= sel_erx_d;
            o_stb_q    <= o_stb_d;
            pend_cnt_q <= pend_cnt_d;
            for (int k = 0; k < MAX_SRC; k++) begin
                erx_slot_q[k] <= erx_slot_d[k];
            end
        end
    end

    assign o_stb     = o_stb_q;
    assign o_eid     = sel_eid_q;
    assign o_erx     = sel_erx_q;
    assign ovf_flags = ovf_q[EVT_NUM-1:0];
    assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_eco32_core_ifu_evm_arb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for eco32_core_ifu_evm_arb (EVT_NUM = 16).
// Expected presentations are pushed to a scoreboard queue when the strobes are
// driven and popped when the DUT raises o_stb. Single-source vectors come from
// a table; round-robin, mask, overflow, ack/strobe collision and reset are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_eco32_core_ifu_evm_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ev_stb;
    logic [63:0] ev_erx;
    logic [15:0] ev_mask;
    logic        o_stb;
    logic [3:0]  o_eid;
    logic [3:0]  o_erx;
    logic        o_ack;
    logic [15:0] ovf_flags;
    logic        ovf_clr;
    logic [4:0]  pend_cnt;

    eco32_core_ifu_evm_arb #(.EVT_NUM(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_stb    (ev_stb),
        .ev_erx    (ev_erx),
        .ev_mask   (ev_mask),
        .o_stb     (o_stb),
        .o_eid     (o_eid),
        .o_erx     (o_erx),
        .o_ack     (o_ack),
        .ovf_flags (ovf_flags),
        .ovf_clr   (ovf_clr),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] eid;
        logic [3:0] erx;
    } ev_t;

    typedef struct {
        int         src;
        logic [3:0] erx;
        logic [3:0] exp_eid;
        logic [3:0] exp_erx;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs [5];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] erx_at(input int k, input logic [3:0] v);
        logic [63:0] r;
        r = 64'd0;
        r[4*k +: 4] = v;
        return r;
    endfunction

    task automatic pulse(input logic [15:0] stb, input logic [63:0] erx);
        ev_stb = stb;
        ev_erx = erx;
        tick();
        ev_stb = 16'd0;
        ev_erx = 64'd0;
    endtask

    task automatic push_exp(input logic [3:0] eid, input logic [3:0] erx);
        ev_t e;
        e.eid = eid;
        e.erx = erx;
        exp_q.push_back(e);
    endtask

    // Bounded wait for o_stb.
    task automatic wait_stb(input int budget, output bit seen);
        int c;
        seen = 1'b0;
        c = 0;
        while (!seen && c < budget) begin
            if (o_stb === 1'b1) begin
                seen = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        if (o_stb === 1'b1) seen = 1'b1;
    endtask

    // Wait for a presentation and compare it with the scoreboard head.
    task automatic expect_present(input string name);
        bit  seen;
        ev_t e;
        wait_stb(8, seen);
        check({name, " stb"}, {31'd0, seen}, 32'd1);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got eid %0d", name, o_eid);
        end else begin
            e = exp_q.pop_front();
            check({name, " eid"}, 32'(o_eid), 32'(e.eid));
            check({name, " erx"}, 32'(o_erx), 32'(e.erx));
        end
    endtask

    task automatic ack(input string name);
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        check({name, " stb_drop"}, 32'(o_stb), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit any_stb;

        vecs[0] = '{src: 0,  erx: 4'h3, exp_eid: 4'd0,  exp_erx: 4'h3};
        vecs[1] = '{src: 15, erx: 4'hF, exp_eid: 4'd15, exp_erx: 4'hF};
        vecs[2] = '{src: 8,  erx: 4'h0, exp_eid: 4'd8,  exp_erx: 4'h0};
        vecs[3] = '{src: 12, erx: 4'h7, exp_eid: 4'd12, exp_erx: 4'h7};
        vecs[4] = '{src: 5,  erx: 4'hA, exp_eid: 4'd5,  exp_erx: 4'hA};

        rst     = 1'b1;
        ev_stb  = 16'd0;
        ev_erx  = 64'd0;
        ev_mask = 16'hFFFF;
        o_ack   = 1'b0;
        ovf_clr = 1'b0;
        #12;
        check("reset o_stb", 32'(o_stb), 32'd0);
        check("reset eid/erx", 32'({o_eid, o_erx}), 32'd0);
        check("reset ovf", 32'(ovf_flags), 32'd0);
        check("reset pend_cnt", 32'(pend_cnt), 32'd0);
        #5;
        rst = 1'b0;
        tick();

        // Single event on source 5 with a 10-cycle hold.
        pulse(16'h0020, erx_at(5, 4'hA));
        check("single lat0", 32'(o_stb), 32'd0);
        tick();
        check("single lat1", 32'({o_stb, o_eid, o_erx}), 32'h15A);
        check("single pend_cnt", 32'(pend_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("single hold", 32'({o_stb, o_eid, o_erx}), 32'h15A);
        end
        ack("single");
        tick();
        check("single pend_cnt0", 32'(pend_cnt), 32'd0);

        // Round-robin 1, 3, 14 from rr_ptr=5 after the first test? rr_ptr is 5
        // here, so 14 comes first, then the wrap gives 1 and 3.
        pulse(16'h400A, erx_at(1, 4'h1) | erx_at(3, 4'h3) | erx_at(14, 4'hE));
        push_exp(4'd14, 4'hE);
        push_exp(4'd1, 4'h1);
        push_exp(4'd3, 4'h3);
        for (int i = 0; i < 3; i++) begin
            expect_present("rr_a");
            ack("rr_a");
        end
        // rr_ptr=3: 1, 3, 14 strobed together now present in order 14, 1, 3
        // again, so use 1, 3 with a pointer parked on 14 instead.
        pulse(16'h4000, erx_at(14, 4'h9));
        push_exp(4'd14, 4'h9);
        expect_present("rr_park");
        ack("rr_park");
        pulse(16'h400A, erx_at(1, 4'h1) | erx_at(3, 4'h3) | erx_at(14, 4'hE));
        push_exp(4'd1, 4'h1);
        push_exp(4'd3, 4'h3);
        push_exp(4'd14, 4'hE);
        for (int i = 0; i < 3; i++) begin
            expect_present("rr_b");
            ack("rr_b");
        end
        pulse(16'h000A, erx_at(1, 4'h5) | erx_at(3, 4'h6));
        push_exp(4'd1, 4'h5);
        push_exp(4'd3, 4'h6);
        for (int i = 0; i < 2; i++) begin
            expect_present("rr_wrap");
            ack("rr_wrap");
        end

        // Table of single-source vectors with latency check.
        for (int v = 0; v < 5; v++) begin
            pulse(16'd1 << vecs[v].src, erx_at(vecs[v].src, vecs[v].erx));
            push_exp(vecs[v].exp_eid, vecs[v].exp_erx);
            check("vec lat0", 32'(o_stb), 32'd0);
            tick();
            check("vec lat1", 32'(o_stb), 32'd1);
            expect_present("vec");
            check("vec ovf", 32'(ovf_flags), 32'd0);
            ack("vec");
        end

        // Mask: 2 masked, only 7 is offered.
        ev_mask = 16'hFFFB;
        pulse(16'h0084, erx_at(2, 4'h2) | erx_at(7, 4'h7));
        push_exp(4'd7, 4'h7);
        expect_present("mask");
        check("mask pend_cnt", 32'(pend_cnt), 32'd2);
        ack("mask");
        for (int i = 0; i < 4; i++) tick();
        check("mask blocked", 32'(o_stb), 32'd0);
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        tick();
        check("idle ack pend_cnt", 32'(pend_cnt), 32'd1);
        check("idle ack stb", 32'(o_stb), 32'd0);
        ev_mask = 16'hFFFF;
        push_exp(4'd2, 4'h2);
        expect_present("unmask");
        ack("unmask");

        // Overflow on the locked source: presented erx stays the old one.
        pulse(16'h0010, erx_at(4, 4'h1));
        push_exp(4'd4, 4'h1);
        expect_present("ovf");
        pulse(16'h0010, erx_at(4, 4'h2));
        check("ovf flag", 32'(ovf_flags), 32'h0010);
        check("ovf erx held", 32'(o_erx), 32'h1);
        ack("ovf");
        tick();
        check("ovf pend_cnt", 32'(pend_cnt), 32'd0);
        check("ovf no re-offer", 32'(o_stb), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf_flags), 32'd0);

        // ovf_clr colliding with a new overflow: the overflow bit wins.
        pulse(16'h0040, erx_at(6, 4'h3));
        push_exp(4'd6, 4'h3);
        expect_present("ovf_win");
        ovf_clr = 1'b1;
        pulse(16'h0040, erx_at(6, 4'h4));
        ovf_clr = 1'b0;
        check("ovf_win flag", 32'(ovf_flags), 32'h0040);
        ack("ovf_win");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_win clr", 32'(ovf_flags), 32'd0);
        check("ovf_win lost", 32'(o_stb), 32'd0);

        // Strobe of the locked source on the ack edge re-arms it.
        pulse(16'h0200, erx_at(9, 4'h1));
        push_exp(4'd9, 4'h1);
        expect_present("same");
        o_ack = 1'b1;
        pulse(16'h0200, erx_at(9, 4'h6));
        o_ack = 1'b0;
        check("same stb_drop", 32'(o_stb), 32'd0);
        check("same no ovf", 32'(ovf_flags), 32'd0);
        push_exp(4'd9, 4'h6);
        expect_present("same re");
        ack("same re");

        // Asynchronous reset in LOCK with three pending.
        pulse(16'h0C01, erx_at(0, 4'h1) | erx_at(10, 4'h2) | erx_at(11, 4'h3));
        wait_stb(8, seen);
        check("rst pre stb", {31'd0, seen}, 32'd1);
        check("rst pre pend_cnt", 32'(pend_cnt), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst async stb", 32'(o_stb), 32'd0);
        check("rst async pend_cnt", 32'(pend_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        any_stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_stb === 1'b1) any_stb = 1'b1;
        end
        check("rst discard", {31'd0, any_stb}, 32'd0);
        pulse(16'h0800, erx_at(11, 4'h5));
        push_exp(4'd11, 4'h5);
        expect_present("post rst");
        ack("post rst");

        check("sb drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
